// File: rtl/prirv32_wb_arbiter.sv
// Writeback arbiter for the register file write port, with a load scoreboard for decode hazards.
// Define PRIRV32_WB_RR_EN for round-robin conflict arbitration; the default is fixed LD priority.
module prirv32_wb_arbiter (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_ready_o,
    input  logic        ld_valid_i,
    input  logic [4:0]  ld_waddr_i,
    input  logic [31:0] ld_wdata_i,
    output logic        ld_ready_o,
    input  logic        sb_set_i,
    input  logic [4:0]  sb_addr_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic        hazard_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o
);

    logic        w_ldWins;
    logic        w_exAcc;
    logic        w_ldAcc;
    logic [31:0] w_busy;
    logic [31:1] w_setMask;
    logic [31:1] w_clrMask;
    logic [31:1] r_busy;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

`ifdef PRIRV32_WB_RR_EN
    // Set when EX won the most recent conflict; reset value lets LD win the first one.
    logic r_exLast;

    assign w_ldWins = r_exLast;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_exLast <= 1'b1;
        end else if (ex_valid_i && ld_valid_i) begin
            r_exLast <= ~w_ldWins;
        end
    end
`else
    assign w_ldWins = 1'b1;
`endif

    assign ld_ready_o = ld_valid_i && (!ex_valid_i || w_ldWins);
    assign ex_ready_o = ex_valid_i && (!ld_valid_i || !w_ldWins);
    assign w_ldAcc    = ld_ready_o;
    assign w_exAcc    = ex_ready_o;

    assign w_busy   = {r_busy, 1'b0};
    assign hazard_o = w_busy[rs1_i] | w_busy[rs2_i];

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        for (int i = 1; i < 32; i++) begin
            w_setMask[i] = sb_set_i && (sb_addr_i == 5'(i));
            w_clrMask[i] = w_ldAcc && (ld_waddr_i == 5'(i));
        end
    end

    // Clear is applied before set so a load issued to the same register stays pending.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clrMask) | w_setMask;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_exAcc) begin
            r_we    <= (ex_waddr_i != 5'd0);
            r_waddr <= ex_waddr_i;
            r_wdata <= ex_wdata_i;
        end else if (w_ldAcc) begin
            r_we    <= (ld_waddr_i != 5'd0);
            r_waddr <= ld_waddr_i;
            r_wdata <= ld_wdata_i;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign we_o    = r_we;
    assign waddr_o = r_waddr;
    assign wdata_o = r_wdata;

endmodule

// File: tb/tb_prirv32_wb_arbiter.sv
// Table-driven bench for prirv32_wb_arbiter with a queue of expected write-port values.
module tb_prirv32_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [4:0]  ex_waddr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic        ex_ready_o;
    logic        ld_valid_i = 1'b0;
    logic [4:0]  ld_waddr_i = '0;
    logic [31:0] ld_wdata_i = '0;
    logic        ld_ready_o;
    logic        sb_set_i = 1'b0;
    logic [4:0]  sb_addr_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic        hazard_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    prirv32_wb_arbiter dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
        .ld_valid_i(ld_valid_i), .ld_waddr_i(ld_waddr_i), .ld_wdata_i(ld_wdata_i), .ld_ready_o(ld_ready_o),
        .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        exV;
        logic [4:0]  exA;
        logic [31:0] exD;
        logic        ldV;
        logic [4:0]  ldA;
        logic [31:0] ldD;
        logic        sbS;
        logic [4:0]  sbA;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        eExR;
        logic        eLdR;
        logic        eHz;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  expQ[$];
    int   checkCount = 0;
    int   passCount = 0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;

    function automatic vec_t mk(logic exV, logic [4:0] exA, logic [31:0] exD,
                                logic ldV, logic [4:0] ldA, logic [31:0] ldD,
                                logic sbS, logic [4:0] sbA, logic [4:0] rs1, logic [4:0] rs2,
                                logic eExR, logic eLdR, logic eHz);
        vec_t v;
        v.exV = exV; v.exA = exA; v.exD = exD;
        v.ldV = ldV; v.ldA = ldA; v.ldD = ldD;
        v.sbS = sbS; v.sbA = sbA; v.rs1 = rs1; v.rs2 = rs2;
        v.eExR = eExR; v.eLdR = eLdR; v.eHz = eHz;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        ex_valid_i = v.exV; ex_waddr_i = v.exA; ex_wdata_i = v.exD;
        ld_valid_i = v.ldV; ld_waddr_i = v.ldA; ld_wdata_i = v.ldD;
        sb_set_i = v.sbS; sb_addr_i = v.sbA; rs1_i = v.rs1; rs2_i = v.rs2;
    endtask

    // Expected write port contents one cycle after the grant, from the table's grant columns.
    task automatic pushExpected(input vec_t v);
        wr_t w;
        if (v.eExR) begin
            mAddr = v.exA; mData = v.exD; w.we = (v.exA != 5'd0);
        end else if (v.eLdR) begin
            mAddr = v.ldA; mData = v.ldD; w.we = (v.ldA != 5'd0);
        end else begin
            w.we = 1'b0;
        end
        w.addr = mAddr;
        w.data = mData;
        expQ.push_back(w);
    endtask

    task automatic popAndCheck(input int idx);
        wr_t w;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_empty[%0d]: got no entry, expected one", idx);
        end else begin
            w = expQ.pop_front();
            checkOutput($sformatf("we[%0d]", idx), 32'(we_o), 32'(w.we));
            checkOutput($sformatf("waddr[%0d]", idx), 32'(waddr_o), 32'(w.addr));
            checkOutput($sformatf("wdata[%0d]", idx), wdata_o, w.data);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // exV exA exD           ldV ldA ldD            sbS sbA rs1 rs2 eEx eLd eHz
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0,  0,  0, 1, 0, 0));
        vecs.push_back(idle);
        vecs.push_back(mk(0, 0, 0,            1, 0, 32'h1234,     0, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 7,  7,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  7,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            1, 7, 32'h77,       0, 0,  7,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  7,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9,  0,  9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 9, 32'h99,       1, 9,  0,  9, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  0,  9, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 10, 10, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 10, 32'hAA,      1, 9,  9, 10, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 10,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 32'h5,        0, 0, 0,            0, 0,  9,  0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,  9,  0, 0, 0, 1));
`ifdef PRIRV32_WB_RR_EN
        vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,       0, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,       0, 0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,       0, 0,  0,  0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,       0, 0,  0,  0, 1, 0, 0));
`else
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1, 32'h11,   1, 2, 32'h22,       0, 0,  0,  0, 0, 1, 0));
`endif
        vecs.push_back(idle);

        // Reset held from time zero: outputs must be clear.
        #1;
        checkOutput("rst_we", 32'(we_o), 32'd0);
        checkOutput("rst_waddr", 32'(waddr_o), 32'd0);
        checkOutput("rst_wdata", wdata_o, 32'd0);
        #13 rst_n = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("ex_ready[%0d]", i), 32'(ex_ready_o), 32'(vecs[i].eExR));
            checkOutput($sformatf("ld_ready[%0d]", i), 32'(ld_ready_o), 32'(vecs[i].eLdR));
            checkOutput($sformatf("hazard[%0d]", i), 32'(hazard_o), 32'(vecs[i].eHz));
            pushExpected(vecs[i]);
            @(posedge clk_i); #1;
            popAndCheck(i);
        end

        // Asynchronous reset in the middle of an EX transfer.
        applyStimulus(mk(1, 3, 32'h33, 0, 0, 0, 0, 0, 9, 10, 1, 0, 1));
        @(posedge clk_i); #1;
        checkOutput("mid_we_before", 32'(we_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", 32'(we_o), 32'd0);
        checkOutput("mid_rst_waddr", 32'(waddr_o), 32'd0);
        checkOutput("mid_rst_wdata", wdata_o, 32'd0);
        checkOutput("mid_rst_hazard", 32'(hazard_o), 32'd0);

        // After reset, LD must win the first conflict in either build.
        applyStimulus(mk(1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 0, 0, 0, 1, 0));
        #1 rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ld_ready", 32'(ld_ready_o), 32'd1);
        checkOutput("post_rst_ex_ready", 32'(ex_ready_o), 32'd0);
        @(posedge clk_i); #1;
        checkOutput("post_rst_we", 32'(we_o), 32'd1);
        checkOutput("post_rst_waddr", 32'(waddr_o), 32'd6);
        checkOutput("post_rst_wdata", wdata_o, 32'h66);
        applyStimulus(idle);
        @(posedge clk_i); #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
